dff_pipe_r: RTL and testbench



---
 rtl/dff_pipe_r.sv | 115 +++++++++++
 tb/tb_dff_pipe_r.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe_r.sv
// dff_pipe_r -- elastic WIDTH-bit, DEPTH-stage register pipeline.
//
// Every stage has a data register and a valid bit. Upstream and downstream
// both use a valid/ready handshake. Empty stages fill from upstream even
// while the output is stalled, so bubbles collapse. A synchronous flush
// drops all valid beats but keeps the data registers.
//
// Optional feature macro: DFF_PIPE_COUNT_EN
//   defined   : count is a register tracking the number of valid stages
//   undefined : count is tied to zero and no counter is built
//
// Parameters:
//   WIDTH  data width in bits (>= 1)
//   DEPTH  number of register stages (>= 1)
//   CW     width of count, derived from DEPTH (do not override)
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   flush    synchronous clear of all stage valid bits
//   s_valid  upstream beat valid
//   s_data   upstream beat data
//   s_ready  pipeline accepts a beat this cycle
//   m_valid  output beat valid (masked during flush)
//   m_data   output beat data (last stage)
//   m_ready  downstream accepts the output beat
//   count    number of valid stages (zero when the counter is not built)
module dff_pipe_r #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic             carry;

  // A stage advances when it holds a beat and the stage after it is empty
  // or is itself advancing. The chain is walked from the output end with a
  // running carry so that each bit depends only on v and m_ready.
  always_comb begin
    adv          = '0;
    carry        = v[DEPTH-1] & m_ready;
    adv[DEPTH-1] = carry;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      carry              = v[DEPTH-2-i] & (~v[DEPTH-1-i] | carry);
      adv[DEPTH-2-i]     = carry;
    end
  end

  assign s_ready = reset_n & ~flush & (~v[0] | adv[0]);
  assign m_valid = v[DEPTH-1] & ~flush;
  assign m_data  = d[DEPTH-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      if (s_valid && s_ready) begin
        d[0] <= s_data;
        v[0] <= 1'b1;
      end else if (adv[0]) begin
        v[0] <= 1'b0;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (adv[i-1]) begin
          d[i] <= d[i-1];
          v[i] <= 1'b1;
        end else if (adv[i]) begin
          v[i] <= 1'b0;
        end
      end
    end
  end

`ifdef DFF_PIPE_COUNT_EN
  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CW'(1);
    end else if (out_xfer && !in_xfer) begin
      count <= count - CW'(1);
    end
  end
`else
  assign count = '0;
`endif

endmodule

// File: tb/tb_dff_pipe_r.sv
// Bench for dff_pipe_r: a DEPTH=2 and a DEPTH=4 instance share one set of
// inputs. A beat-moving model predicts every output at each falling edge,
// and directed literal expectations pin the model at key points.
module tb_dff_pipe_r;

  logic        clk;
  logic        rn;
  logic        fl;
  logic        sv;
  logic [31:0] sd;
  logic        mr;

  logic        sr2, mv2;
  logic [31:0] md2;
  logic [1:0]  cnt2;
  logic        sr4, mv4;
  logic [31:0] md4;
  logic [2:0]  cnt4;

  int checks = 0;
  int errors = 0;

  // model state: per instance, per slot
  logic        mvld [2][4];
  logic [31:0] mdat [2][4];

  dff_pipe_r #(.WIDTH(32), .DEPTH(2)) u2 (
    .clk(clk), .reset_n(rn), .flush(fl), .s_valid(sv), .s_data(sd),
    .s_ready(sr2), .m_valid(mv2), .m_data(md2), .m_ready(mr), .count(cnt2)
  );

  dff_pipe_r #(.WIDTH(32), .DEPTH(4)) u4 (
    .clk(clk), .reset_n(rn), .flush(fl), .s_valid(sv), .s_data(sd),
    .s_ready(sr4), .m_valid(mv4), .m_data(md4), .m_ready(mr), .count(cnt4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic int ecnt(input int n);
`ifdef DFF_PIPE_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Beats move toward the output one slot per cycle whenever the slot ahead
  // is (or becomes) empty; the output slot empties on a downstream accept.
  task automatic model_cycle(input int k, input int dep, input logic a_sr,
                             input logic a_mv, input logic [31:0] a_md, input int a_cnt);
    logic        e_sr, e_mv;
    logic [31:0] e_md;
    int          pc;
    pc = 0;
    for (int j = 0; j < dep; j++) pc += int'(mvld[k][j]);
    if (!rn) begin
      e_sr = 1'b0; e_mv = 1'b0; e_md = '0; pc = 0;
      for (int j = 0; j < 4; j++) begin
        mvld[k][j] = 1'b0;
        mdat[k][j] = '0;
      end
    end else begin
      e_mv = mvld[k][dep-1] & ~fl;
      e_md = mdat[k][dep-1];
      if (fl) begin
        e_sr = 1'b0;
        for (int j = 0; j < 4; j++) mvld[k][j] = 1'b0;
      end else begin
        if (mvld[k][dep-1] && mr) mvld[k][dep-1] = 1'b0;
        for (int j = dep - 2; j >= 0; j--) begin
          if (mvld[k][j] && !mvld[k][j+1]) begin
            mdat[k][j+1] = mdat[k][j];
            mvld[k][j+1] = 1'b1;
            mvld[k][j]   = 1'b0;
          end
        end
        e_sr = ~mvld[k][0];
        if (sv && e_sr) begin
          mdat[k][0] = sd;
          mvld[k][0] = 1'b1;
        end
      end
    end
    chk($sformatf("model_s_ready_d%0d", dep), {31'b0, a_sr}, {31'b0, e_sr});
    chk($sformatf("model_m_valid_d%0d", dep), {31'b0, a_mv}, {31'b0, e_mv});
    chk($sformatf("model_m_data_d%0d", dep), a_md, e_md);
    chk($sformatf("model_count_d%0d", dep), a_cnt, ecnt(pc));
  endtask

  always @(negedge clk) begin
    model_cycle(0, 2, sr2, mv2, md2, int'(cnt2));
    model_cycle(1, 4, sr4, mv4, md4, int'(cnt4));
  end

  task automatic step(input logic i_sv, input logic [31:0] i_sd, input logic i_mr, input logic i_fl);
    @(posedge clk);
    #2;
    sv = i_sv; sd = i_sd; mr = i_mr; fl = i_fl;
    #1;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #2;
    rn = 1'b0; sv = 1'b0; sd = '0; mr = 1'b0; fl = 1'b0;
    @(posedge clk);
    #2;
    rn = 1'b1;
  endtask

  initial begin
    rn = 1'b1; fl = 1'b0; sv = 1'b0; sd = '0; mr = 1'b0;
    #1 rn = 1'b0;
    #2;
    chk("rst_m_valid_d2", {31'b0, mv2}, 32'd0);
    chk("rst_m_data_d2", md2, 32'd0);
    chk("rst_s_ready_d2", {31'b0, sr2}, 32'd0);
    chk("rst_count_d2", {30'b0, cnt2}, 32'd0);
    chk("rst_m_valid_d4", {31'b0, mv4}, 32'd0);
    @(posedge clk);
    #2 rn = 1'b1;

    // streaming with m_ready held high
    step(1'b1, 32'h11111111, 1'b1, 1'b0);
    step(1'b1, 32'h22222222, 1'b1, 1'b0);
    step(1'b1, 32'h33333333, 1'b1, 1'b0);
    chk("stream_first_data", md2, 32'h11111111);
    chk("stream_first_valid", {31'b0, mv2}, 32'd1);
    step(1'b1, 32'h44444444, 1'b1, 1'b0);
    chk("stream_second_data", md2, 32'h22222222);
    chk("stream_count", {30'b0, cnt2}, ecnt(2));
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stream_last_data", md2, 32'h44444444);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stream_empty_valid", {31'b0, mv2}, 32'd0);
    chk("stream_empty_data_held", md2, 32'h44444444);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    // back-pressure: third beat refused until downstream releases
    do_reset;
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    chk("bp_second_ready", {31'b0, sr2}, 32'd1);
    step(1'b1, 32'hC, 1'b0, 1'b0);
    chk("bp_full_ready", {31'b0, sr2}, 32'd0);
    chk("bp_full_data", md2, 32'hA);
    step(1'b1, 32'hC, 1'b1, 1'b0);
    chk("bp_release_ready", {31'b0, sr2}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_out_b", md2, 32'hB);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_out_c", md2, 32'hC);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_drained_valid", {31'b0, mv2}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    // bubble collapse in the four-stage pipe
    do_reset;
    step(1'b1, 32'h4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("bubble_head_valid", {31'b0, mv4}, 32'd1);
    chk("bubble_head_data", md4, 32'h4);
    step(1'b1, 32'h5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("bubble_count", {29'b0, cnt4}, ecnt(2));
    chk("bubble_s_ready", {31'b0, sr4}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bubble_next_data", md4, 32'h5);
    chk("bubble_next_valid", {31'b0, mv4}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    // flush on a full pipe with both handshakes asserted
    do_reset;
    step(1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b1, 32'h2, 1'b0, 1'b0);
    step(1'b1, 32'h3, 1'b0, 1'b0);
    step(1'b1, 32'h4, 1'b0, 1'b0);
    step(1'b1, 32'h5, 1'b1, 1'b1);
    chk("flush_m_valid", {31'b0, mv4}, 32'd0);
    chk("flush_s_ready", {31'b0, sr4}, 32'd0);
    chk("flush_count_before", {29'b0, cnt4}, ecnt(4));
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("after_flush_m_valid", {31'b0, mv4}, 32'd0);
    chk("after_flush_count", {29'b0, cnt4}, 32'd0);
    chk("after_flush_s_ready", {31'b0, sr4}, 32'd1);
    chk("after_flush_data_kept", md4, 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // asynchronous reset between clock edges
    do_reset;
    step(1'b1, 32'h77, 1'b1, 1'b0);
    step(1'b1, 32'h88, 1'b1, 1'b0);
    step(1'b1, 32'h99, 1'b1, 1'b0);
    chk("arst_pre_data", md2, 32'h77);
    #1 rn = 1'b0;
    #1;
    chk("arst_m_valid", {31'b0, mv2}, 32'd0);
    chk("arst_m_data", md2, 32'd0);
    chk("arst_count", {30'b0, cnt2}, 32'd0);
    chk("arst_s_ready", {31'b0, sr2}, 32'd0);
    chk("arst_m_data_d4", md4, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rn = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
